// File: rtl/wb_sram_pkg.sv
// Shared types and constants for the weight-buffer SRAM responder.
// Word and address geometry plus the responder FSM state encoding.
package wb_sram_pkg;

    localparam int WB_WORD_BITS = 32;
    localparam int WB_ADDR_LSB  = 2;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        READ_WAIT = 2'd1,
        RESPOND   = 2'd2
    } wb_sram_state_t;

endpackage

// File: rtl/wb_sram_array.sv
// Single-port weight-buffer storage: one read or one write per enabled cycle.
// Read data is registered and holds its value until the next read.
module wb_sram_array
    import wb_sram_pkg::*;
#(
    parameter int DEPTH_WORDS = 4096,
    parameter int AW          = $clog2(DEPTH_WORDS)
) (
    input  logic                    clock,
    input  logic                    en,
    input  logic                    we,
    input  logic [AW-1:0]           addr,
    input  logic [WB_WORD_BITS-1:0] wdata,
    output logic [WB_WORD_BITS-1:0] rdata
);

    logic [WB_WORD_BITS-1:0] mem [DEPTH_WORDS];

    // No reset: contents must survive a responder reset.
    always_ff @(posedge clock) begin
        if (en) begin
            if (we) begin
                mem[addr] <= wdata;
            end else begin
                rdata <= mem[addr];
            end
        end
    end

endmodule

// File: rtl/wb_sram_responder.sv
// Responder for the PU weight-buffer SRAM read protocol with a loader fill port.
// Reads win over fills; a fill is only taken while IDLE and no read is requested.
module wb_sram_responder
    import wb_sram_pkg::*;
#(
    parameter int DEPTH_WORDS  = 4096,
    parameter int READ_LATENCY = 2
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        WB_SRAM_read,
    input  logic [31:0] WB_SRAM_address,
    output logic        WB_SRAM_ready,
    output logic [31:0] WB_SRAM_data,
    output logic        WB_SRAM_error,
    input  logic        fill_write,
    input  logic [31:0] fill_address,
    input  logic [31:0] fill_data,
    output logic        fill_ack,
    output logic [1:0]  debug_state
);

    localparam int          AW           = $clog2(DEPTH_WORDS);
    localparam logic [29:0] DEPTH_IDX    = 30'(DEPTH_WORDS);
    localparam logic [3:0]  LOAD         = 4'(READ_LATENCY - 1);
    localparam bit          SINGLE_CYCLE = (READ_LATENCY == 1);

    wb_sram_state_t state, state_next;
    logic [3:0]  cnt, cnt_next;
    logic        accept_read, accept_fill;
    logic        oor_q;
    logic [31:0] data_hold;
    logic [31:0] arr_rdata;
    logic [31:0] resp_word;
    logic [29:0] rd_idx, fill_idx;
    logic        rd_in_range, fill_in_range;
    logic        arr_en;
    logic [AW-1:0] arr_addr;
    logic        unused_addr_bits;

    assign rd_idx        = WB_SRAM_address[31:WB_ADDR_LSB];
    assign fill_idx      = fill_address[31:WB_ADDR_LSB];
    assign rd_in_range   = rd_idx < DEPTH_IDX;
    assign fill_in_range = fill_idx < DEPTH_IDX;
    assign unused_addr_bits = ^{WB_SRAM_address[1:0], fill_address[1:0]};

    always_comb begin
        state_next  = state;
        cnt_next    = cnt;
        accept_read = 1'b0;
        accept_fill = 1'b0;
        case (state)
            IDLE: begin
                if (WB_SRAM_read) begin
                    accept_read = 1'b1;
                    cnt_next    = LOAD;
                    state_next  = SINGLE_CYCLE ? RESPOND : READ_WAIT;
                end else if (fill_write && !fill_ack) begin
                    // fill_ack high means this held request was already written.
                    accept_fill = 1'b1;
                end
            end
            READ_WAIT: begin
                cnt_next = cnt - 4'd1;
                if (cnt <= 4'd1) begin
                    state_next = RESPOND;
                end
            end
            RESPOND: state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state     <= IDLE;
            cnt       <= 4'd0;
            oor_q     <= 1'b0;
            fill_ack  <= 1'b0;
            data_hold <= 32'd0;
        end else begin
            state    <= state_next;
            cnt      <= cnt_next;
            fill_ack <= accept_fill;
            if (accept_read) begin
                oor_q <= !rd_in_range;
            end
            if (state == RESPOND) begin
                data_hold <= resp_word;
            end
        end
    end

    // The array is read at acceptance; its output register holds until RESPOND.
    assign arr_en   = (accept_read && rd_in_range) || (accept_fill && fill_in_range);
    assign arr_addr = accept_read ? rd_idx[AW-1:0] : fill_idx[AW-1:0];

    wb_sram_array #(
        .DEPTH_WORDS(DEPTH_WORDS)
    ) u_array (
        .clock (clock),
        .en    (arr_en),
        .we    (accept_fill),
        .addr  (arr_addr),
        .wdata (fill_data),
        .rdata (arr_rdata)
    );

    assign resp_word     = oor_q ? 32'd0 : arr_rdata;
    assign WB_SRAM_ready = (state == RESPOND);
    assign WB_SRAM_error = (state == RESPOND) && oor_q;
    assign WB_SRAM_data  = (state == RESPOND) ? resp_word : data_hold;
    assign debug_state   = state;

endmodule
